// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-side types and constants for the instruction prefetch path.
package riscv_fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_prefetch_queue_chk.sv
// Invariant checks for the prefetch queue counters and FIFOs.
module instr_prefetch_queue_chk #(
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input logic          clk,
    input logic          rst,
    input logic          push,
    input logic [CW-1:0] occ,
    input logic          rsp_valid,
    input logic [CW-1:0] live_cnt,
    input logic [CW-1:0] drop_cnt,
    input logic [CW-1:0] tag_occ
);

    a_push_not_full: assert property (@(posedge clk) disable iff (!rst)
        push |-> (occ < CW'(DEPTH)));

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
        rsp_valid |-> ((live_cnt != {CW{1'b0}}) || (drop_cnt != {CW{1'b0}})));

    a_tags_track_live: assert property (@(posedge clk) disable iff (!rst)
        tag_occ == live_cnt);

endmodule

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CW-1:0]    occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    occ_q, occ_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_pop_s  = pop && (occ_q != {CW{1'b0}});
    assign do_push_s = push && (occ_q != CW'(DEPTH));

    // Next-state for storage, pointers and occupancy; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            occ_d    = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            occ_d = occ_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            occ_q    <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = (occ_q != {CW{1'b0}}) ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues word fetches, queues responses in order
// with their PC, and flushes/discards stale responses on a redirect.
module instr_prefetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr_code,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_4
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;
    localparam int EW = $bits(fetch_entry_t);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   live_cnt_q, live_cnt_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]   occ_s;
    logic [CW-1:0]   tag_occ_s;
    logic [XLEN-1:0] tag_head_s;
    logic [EW-1:0]   head_bits_s;
    fetch_entry_t    head_s;
    fetch_entry_t    rsp_entry_s;
    logic [SW-1:0]   inflight_s;
    logic [SW-1:0]   outstanding_s;
    logic            accept_s;
    logic            keep_s;
    logic            drop_rsp_s;
    logic            pop_s;

    // Queue slots are reserved at issue time so a response always finds room.
    assign inflight_s    = SW'(occ_s) + SW'(live_cnt_q) + SW'(drop_cnt_q);
    assign outstanding_s = SW'(live_cnt_q) + SW'(drop_cnt_q);

    assign imem_req_valid = rst && !redirect_valid && (inflight_s < SW'(DEPTH));
    assign imem_req_addr  = word_align(fetch_pc_q);
    assign accept_s       = imem_req_valid && imem_req_ready;

    assign drop_rsp_s = imem_rsp_valid && (drop_cnt_q != {CW{1'b0}});
    assign keep_s     = imem_rsp_valid && !redirect_valid
                        && (drop_cnt_q == {CW{1'b0}}) && (live_cnt_q != {CW{1'b0}});
    assign pop_s      = instr_valid && instr_ready && !redirect_valid;

    assign rsp_entry_s = {tag_head_s, imem_rsp_data};

    // Fetch PC and in-flight accounting; a redirect converts live requests into drops.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        live_cnt_d = live_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            live_cnt_d = {CW{1'b0}};
            if (imem_rsp_valid && (outstanding_s != {SW{1'b0}})) begin
                drop_cnt_d = drop_cnt_q + live_cnt_q - CW'(1);
            end else begin
                drop_cnt_d = drop_cnt_q + live_cnt_q;
            end
        end else begin
            if (accept_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            live_cnt_d = live_cnt_q + CW'(accept_s) - CW'(keep_s);
            if (drop_rsp_s) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // Fetch state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            live_cnt_q <= {CW{1'b0}};
            drop_cnt_q <= {CW{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            live_cnt_q <= live_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // PC of every live request, oldest first; popped as its response is kept.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (accept_s),
        .push_data (imem_req_addr),
        .pop       (keep_s),
        .occ       (tag_occ_s),
        .head      (tag_head_s)
    );

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_entry_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (keep_s),
        .push_data (rsp_entry_s),
        .pop       (pop_s),
        .occ       (occ_s),
        .head      (head_bits_s)
    );

    assign head_s      = fetch_entry_t'(head_bits_s);
    assign instr_valid = (occ_s != {CW{1'b0}});
    assign instr_code  = head_s.instr;
    assign instr_pc    = head_s.pc;
    assign instr_pc_4  = instr_valid ? (head_s.pc + 32'd4) : {XLEN{1'b0}};

    instr_prefetch_queue_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .push      (keep_s),
        .occ       (occ_s),
        .rsp_valid (imem_rsp_valid),
        .live_cnt  (live_cnt_q),
        .drop_cnt  (drop_cnt_q),
        .tag_occ   (tag_occ_s)
    );

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench: in-order memory model with configurable latency and a
// scoreboard of expected PCs pushed at request acceptance.
module tb_instr_prefetch_queue;

    logic        clk            = 1'b0;
    logic        rst            = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        instr_valid;
    logic        instr_ready    = 1'b0;
    logic [31:0] instr_code;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_4;

    instr_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_code     (instr_code),
        .instr_pc       (instr_pc),
        .instr_pc_4     (instr_pc_4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int last_due = 0;
    int first_valid_cyc = -1;
    int obs_inflight = 0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    logic [31:0] acc_addr_log[$];
    int          acc_cyc_log[$];

    logic        obs_req_valid, obs_instr_valid, obs_rsp_valid;
    logic [31:0] obs_req_addr, obs_pc, obs_pc_4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: memory drives its response, outputs are sampled, scoreboard updated.
    task automatic step();
        int          due;
        logic [31:0] e;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        obs_inflight   = mem_addr_q.size();
        if (!rst) begin
            mem_addr_q.delete();
            mem_due_q.delete();
            exp_pc_q.delete();
            last_due = cyc;
        end else if (mem_addr_q.size() != 0 && mem_due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr_q[0]);
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        #1;
        obs_req_valid   = imem_req_valid;
        obs_req_addr    = imem_req_addr;
        obs_instr_valid = instr_valid;
        obs_rsp_valid   = imem_rsp_valid;
        obs_pc          = instr_pc;
        obs_pc_4        = instr_pc_4;
        if (first_valid_cyc < 0 && instr_valid) first_valid_cyc = cyc;
        if (imem_req_valid && imem_req_ready) begin
            due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = due;
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(due);
            exp_pc_q.push_back(imem_req_addr);
            acc_addr_log.push_back(imem_req_addr);
            acc_cyc_log.push_back(cyc);
        end
        if (redirect_valid) begin
            exp_pc_q.delete();
        end else if (instr_valid && instr_ready) begin
            if (exp_pc_q.size() == 0) begin
                check_eq("sb_unexpected_out", 32'(exp_pc_q.size()), 32'd1);
            end else begin
                e = exp_pc_q.pop_front();
                check_eq("sb_pc", instr_pc, e);
                check_eq("sb_code", instr_code, mem_word(e));
                check_eq("sb_pc_4", instr_pc_4, e + 32'd4);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect_valid = 1'b0;
        step();
        rst = 1'b1;
        acc_addr_log.delete();
        acc_cyc_log.delete();
        first_valid_cyc = -1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        step();
        while (!obs_instr_valid && n < 30) begin
            step();
            n++;
        end
        check_eq({tag, "_timeout"}, 32'(obs_instr_valid), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b1;
        while ((mem_addr_q.size() != 0 || instr_valid) && n < 40) begin
            step();
            n++;
        end
        check_eq({tag, "_drained"}, 32'(exp_pc_q.size()), 32'd0);
    endtask

    initial begin
        int idx;
        int exp_drop;

        // Reset state.
        rst = 1'b0;
        step();
        step();
        check_eq("rst_req_valid", 32'(obs_req_valid), 32'd0);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_code", instr_code, 32'd0);
        check_eq("rst_pc", instr_pc, 32'd0);
        check_eq("rst_pc_4", instr_pc_4, 32'd0);

        // Back-to-back issue and the full-queue cap with the consumer stalled.
        rst = 1'b1;
        acc_addr_log.delete();
        acc_cyc_log.delete();
        first_valid_cyc = -1;
        lat = 1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b0;
        repeat (8) step();
        check_eq("cap_count", 32'(acc_addr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_addr_log.size(); i++) begin
            check_eq("seq_addr", acc_addr_log[i], 32'(i * 4));
            check_eq("seq_cycle", 32'(acc_cyc_log[i]), 32'(acc_cyc_log[0] + i));
        end
        check_eq("first_valid_lat", 32'(first_valid_cyc), 32'(acc_cyc_log[0] + 2));
        check_eq("cap_req_valid", 32'(obs_req_valid), 32'd0);
        check_eq("head_pc", instr_pc, 32'h0);
        check_eq("head_pc_4", instr_pc_4, 32'h4);
        instr_ready = 1'b1;
        imem_req_ready = 1'b1;
        repeat (6) step();
        check_eq("resume_addr", (acc_addr_log.size() > 4) ? acc_addr_log[4] : 32'hFFFF_FFFF, 32'h10);
        drain("cap");

        // Request stall keeps a stable address and produces no duplicate.
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        step();
        step();
        imem_req_ready = 1'b0;
        repeat (3) begin
            step();
            check_eq("stall_valid", 32'(obs_req_valid), 32'd1);
            check_eq("stall_addr", obs_req_addr, 32'h8);
        end
        imem_req_ready = 1'b1;
        repeat (6) step();
        check_eq("stall_next2", (acc_addr_log.size() > 3) ? acc_addr_log[2] : 32'hFFFF_FFFF, 32'h8);
        check_eq("stall_next3", (acc_addr_log.size() > 3) ? acc_addr_log[3] : 32'hFFFF_FFFF, 32'hC);
        drain("stall");

        // Redirect with two stale requests in flight at latency 3.
        do_reset();
        lat = 3;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0104;
        step();
        check_eq("redir_no_req", 32'(obs_req_valid), 32'd0);
        check_eq("redir_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
        redirect_valid = 1'b0;
        step();
        check_eq("redir_flushed", 32'(obs_instr_valid), 32'd0);
        wait_valid("redir");
        check_eq("redir_pc", obs_pc, 32'h0000_0104);
        drain("redir");

        // Redirect coinciding with a response and a pop.
        do_reset();
        lat = 2;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        repeat (8) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        exp_drop = obs_inflight - 1;
        check_eq("coinc_rsp", 32'(obs_rsp_valid), 32'd1);
        check_eq("coinc_head", 32'(obs_instr_valid), 32'd1);
        check_eq("coinc_drop_cnt", 32'(dut.drop_cnt_q), 32'(exp_drop));
        redirect_valid = 1'b0;
        wait_valid("coinc");
        check_eq("coinc_pc", obs_pc, 32'h0000_0200);
        repeat (4) step();
        drain("coinc");

        // Redirect to the top of the address space; PC+4 wraps to zero.
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        idx = acc_addr_log.size();
        redirect_valid = 1'b0;
        wait_valid("wrap");
        check_eq("wrap_pc", obs_pc, 32'hFFFF_FFFC);
        check_eq("wrap_pc_4", obs_pc_4, 32'h0);
        check_eq("wrap_req0", (acc_addr_log.size() > idx + 1) ? acc_addr_log[idx] : 32'h1, 32'hFFFF_FFFC);
        check_eq("wrap_req1", (acc_addr_log.size() > idx + 1) ? acc_addr_log[idx + 1] : 32'h1, 32'h0);
        drain("wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
